// File: rtl/ah_credit_pkg.sv
// Shared types and constants for the AH credit transmitter and its 2-entry buffer.
package ah_credit_pkg;

  localparam int FLIT_W      = 110;
  localparam int CREDITS_DEF = 32;

  typedef logic [FLIT_W-1:0] flit_t;

  // Value latched into credit_err when a credit is returned to a full counter.
  localparam logic CREDIT_ERR_OVF = 1'b1;

  function automatic int cnt_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/ah_skid_buf2.sv
// Two-entry in-order buffer with push/pop and occupancy; push and pop may share an edge.
module ah_skid_buf2 #(
  parameter int WIDTH = 110
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ_q;

  // The owner gates push with occ<2 and pop with occ>0; no internal protection.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign occ  = occ_q;

endmodule

// File: rtl/ah_credit_tx.sv
// Credit-based transmitter feeding the AH snoopable FIFO: buffers up to 2 flits, sends one per held credit.
module ah_credit_tx
  import ah_credit_pkg::*;
#(
  parameter  int WIDTH   = FLIT_W,
  parameter  int CREDITS = CREDITS_DEF,
  localparam int CNT_W   = cnt_width(CREDITS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] wdata,
  output logic             wvalid,
  input  logic             wcredit,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             credit_err,
  output logic             idle
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] head;
  logic [1:0]       occ;
  logic             push;
  logic             send;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Handshake: a flit transfers on an edge where in_valid && in_ready; in_ready
  // depends only on buffer occupancy, never on in_valid, and the producer must
  // hold in_data stable while in_valid is high and in_ready is low.
  assign in_ready = (occ != 2'd2);
  assign push     = in_valid & in_ready;
  // Only credits held before the edge count; a same-cycle wcredit waits a cycle.
  assign send     = (occ != 2'd0) && (cnt_q != '0);

  ah_skid_buf2 #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .push_data (in_data),
    .push      (push),
    .pop       (send),
    .head      (head),
    .occ       (occ)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wvalid <= 1'b0;
      wdata  <= '0;
      cnt_q  <= CNT_MAX;
      err_q  <= 1'b0;
    end else begin
      wvalid <= send;
      if (send) wdata <= head;
      case ({send, wcredit})
        2'b10: cnt_q <= cnt_q - CNT_ONE;
        2'b01: begin
          // A return to a full counter is a downstream protocol error; hold the count.
          if (cnt_q == CNT_MAX) err_q <= CREDIT_ERR_OVF;
          else                  cnt_q <= cnt_q + CNT_ONE;
        end
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign credit_cnt = cnt_q;
  assign credit_err = err_q;
  assign idle       = (occ == 2'd0) && !wvalid && (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_ah_credit_tx.sv
// Directed and randomized checks of ah_credit_tx against a queue-based reference model.
module tb_ah_credit_tx;

  localparam int W       = 110;
  localparam int CREDITS = 32;
  localparam int CNT_W   = 6;

  logic             clk = 1'b0;
  logic             rstn;
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     wdata;
  logic             wvalid;
  logic             wcredit;
  logic [CNT_W-1:0] credit_cnt;
  logic             credit_err;
  logic             idle;

  ah_credit_tx dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wcredit    (wcredit),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // Reference model: accepted-but-unsent flits in order, credits as a plain integer.
  logic [W-1:0] exp_q[$];
  int           m_cnt;
  logic         m_err;
  logic         m_wvalid;
  logic [W-1:0] m_wdata;
  logic         last_acc;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pulse;
  int idx;
  int seq;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_flit();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic check_all();
    chk("wvalid", wvalid, m_wvalid);
    chk("wdata", wdata, m_wdata);
    chk("credit_cnt", credit_cnt, m_cnt);
    chk("in_ready", in_ready, exp_q.size() < 2);
    chk("credit_err", credit_err, m_err);
    chk("idle", idle, (exp_q.size() == 0) && !m_wvalid && (m_cnt == CREDITS));
  endtask

  // One clock of stimulus; the model advances from its pre-edge state.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic c);
    bit acc;
    bit snd;
    in_valid = v;
    in_data  = d;
    wcredit  = c;
    acc = v && (exp_q.size() < 2);
    snd = (exp_q.size() > 0) && (m_cnt > 0);
    @(posedge clk);
    if (snd) m_wdata = exp_q.pop_front();
    if (acc) exp_q.push_back(d);
    m_wvalid = snd;
    if (c && !snd && m_cnt == CREDITS) m_err = 1'b1;
    else m_cnt = m_cnt - int'(snd) + int'(c);
    last_acc = acc;
    #1;
    if (wvalid === 1'b1) n_pulse++;
    check_all();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    wcredit  = 1'b0;
    rstn     = 1'b1;
    #2;
    exp_q.delete();
    m_cnt    = CREDITS;
    m_err    = 1'b0;
    m_wvalid = 1'b0;
    m_wdata  = '0;
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_cnt", credit_cnt, CREDITS);
    chk("rst_err", credit_err, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_wvalid", wvalid, 0);
    rstn = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
  endtask

  initial begin
    rstn     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    wcredit  = 1'b0;
    do_reset();

    // Burst of 40 offered flits with no credit returns.
    n_pulse = 0;
    idx     = 0;
    seq     = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(idx < 40, W'(idx), 1'b0);
      if (last_acc) idx++;
      if (wvalid === 1'b1) begin
        chk("burst_order", wdata, seq);
        seq++;
      end
    end
    chk("burst_pulses", n_pulse, 32);
    chk("burst_cnt0", credit_cnt, 0);
    chk("burst_ready0", in_ready, 0);

    // One returned credit releases exactly flit 32, two cycles after the pulse.
    n_pulse = 0;
    cycle(1'b0, '0, 1'b1);
    chk("sc_no_early", wvalid, 0);
    chk("sc_cnt1", credit_cnt, 1);
    cycle(1'b0, '0, 1'b0);
    chk("sc_wvalid", wvalid, 1);
    chk("sc_data", wdata, 32);
    chk("sc_cnt0", credit_cnt, 0);
    repeat (4) cycle(1'b0, '0, 1'b0);
    chk("sc_one_pulse", n_pulse, 1);

    // Return credits: flit 33 goes on the second edge, then count climbs to 5.
    repeat (6) cycle(1'b0, '0, 1'b1);
    chk("refill_cnt", credit_cnt, 5);

    // Steady state: input and a credit every cycle.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, rand_flit(), 1'b1);
      if (i >= 2) begin
        chk("steady_rate", wvalid, 1);
        chk("steady_cnt", credit_cnt, 6);
      end
    end
    repeat (4) cycle(1'b0, '0, 1'b0);

    // Credit overflow is sticky until reset.
    do_reset();
    cycle(1'b0, '0, 1'b1);
    chk("ovf_cnt", credit_cnt, 32);
    chk("ovf_err", credit_err, 1);
    repeat (3) cycle(1'b1, rand_flit(), 1'b0);
    chk("ovf_sticky", credit_err, 1);
    do_reset();
    chk("ovf_cleared", credit_err, 0);

    // Reset mid-burst, with flits buffered and in flight.
    for (int i = 0; i < 20; i++) cycle(1'b1, rand_flit(), 1'b0);
    chk("mid_busy_cnt", credit_cnt, 13);
    do_reset();
    cycle(1'b1, W'(128'hABC), 1'b0);
    chk("mid_first_wait", wvalid, 0);
    cycle(1'b0, '0, 1'b0);
    chk("mid_sent", wvalid, 1);
    chk("mid_data", wdata, 128'hABC);
    chk("mid_cnt", credit_cnt, 31);

    // Random traffic with a downstream that only returns credits it owes.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), rand_flit(),
            (m_cnt < CREDITS) && ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 50; i++) cycle(1'b0, '0, m_cnt < CREDITS);
    chk("final_idle", idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
